// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_IF_RD = 2'd1,
    TAG_D_RD  = 2'd2
  } resp_tag_e;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter with synchronous clear, used to track consecutive fetch denials.
module starve_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         init_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);

  logic [W-1:0] cnt_reg;

  assign cnt = cnt_reg;
  assign sat = (cnt_reg == W'(MAX));

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && !sat) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port synchronous RAM,
// routing the one-cycle-late read data back to whichever requester was granted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  resp_tag_e        tag_reg;
  logic             misalign_reg;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             aligned;
  logic             d_ok;

  assign aligned = (d_addr[1:0] == 2'b00);
  assign d_ok    = d_req & aligned;

  // Data normally wins; a fetch that has waited STARVE_MAX cycles takes the port once.
  assign if_gnt = init_n & if_req & ~if_kill & (~d_ok | starved);
  assign d_gnt  = init_n & d_ok & ~if_gnt;

  starve_counter #(
    .MAX (STARVE_MAX),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk    (clk),
    .init_n (init_n),
    .inc    (if_req & ~if_gnt),
    .clr    (if_gnt | ~if_req),
    .cnt    (starve_cnt),
    .sat    (starved)
  );

  assign mem_cs   = if_gnt | d_gnt;
  assign mem_we   = d_we & d_gnt;
  assign mem_addr = if_gnt ? (if_addr & WORD_MASK) :
                    d_gnt  ? (d_addr & WORD_MASK)  : '0;
  assign mem_din  = mem_cs ? d_wdata : 32'd0;

  assign stall_if  = if_req & ~if_gnt & ~if_kill;
  assign stall_mem = d_req & ~d_gnt & aligned;

  // A kill in the response cycle discards the fetch data already on mem_dout.
  assign if_rvalid  = (tag_reg == TAG_IF_RD) & ~if_kill;
  assign d_rvalid   = (tag_reg == TAG_D_RD);
  assign if_rdata   = if_rvalid ? mem_dout : 32'd0;
  assign d_rdata    = d_rvalid ? mem_dout : 32'd0;
  assign d_misalign = misalign_reg;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      tag_reg      <= TAG_NONE;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= d_req & ~aligned;
      if (if_gnt) begin
        tag_reg <= TAG_IF_RD;
      end else if (d_gnt && !d_we) begin
        tag_reg <= TAG_D_RD;
      end else begin
        tag_reg <= TAG_NONE;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive fetch denials before fetch priority is forced.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port init_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports if_req input 1 and if_addr input ADDR_W: instruction fetch read request and byte address.
REQ-006 SHALL have port if_kill  input  1  branch flush; cancels the in-flight fetch.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W and d_wdata input 32: data request, write enable, address and write data.
REQ-008 SHALL have outputs if_gnt 1, if_rvalid 1 and if_rdata 32: fetch grant, response valid and response data.
REQ-009 SHALL have outputs d_gnt 1, d_rvalid 1, d_rdata 32 and d_misalign 1: data grant, read-response valid, read data and alignment-error pulse.
REQ-010 SHALL have outputs stall_if 1 and stall_mem 1: pipeline stall requests toward the IF and MEM stages.
REQ-011 SHALL have outputs mem_cs 1, mem_we 1, mem_addr ADDR_W and mem_din 32, plus input mem_dout 32: shared single-port synchronous RAM, read latency 1.

Function
REQ-012 SHALL grant at most one requester per cycle; if_gnt and d_gnt are combinational in the request cycle and never both 1.
REQ-013 SHALL grant data over fetch when both request, unless starve_cnt == STARVE_MAX, in which case fetch wins that cycle.
REQ-014 SHALL increment starve_cnt (saturating at STARVE_MAX) on cycles with if_req=1 and if_gnt=0, and clear it on if_gnt=1 or if_req=0.
REQ-015 SHALL drive mem_cs=1, mem_addr={granted addr[ADDR_W-1:2],2'b00}, mem_we=d_we&d_gnt and mem_din=d_wdata during a granted cycle; mem_cs=0, mem_we=0 and mem_addr/mem_din=0 otherwise.
REQ-016 SHALL keep a response-tag FSM with states NONE, IF_RD and D_RD: next state IF_RD on a fetch grant, D_RD on a data-read grant, NONE otherwise (data writes included).
REQ-017 SHALL assert if_rvalid=1 (D_RD: d_rvalid=1) exactly one cycle after the grant while the tag is IF_RD, with rdata = mem_dout; inactive rdata SHALL be 0.
REQ-018 SHALL, when if_kill=1, force if_gnt=0 that cycle, suppress if_rvalid that cycle, and move a tag of IF_RD to NONE; D_RD SHALL be unaffected.
REQ-019 SHALL, on a data request with d_addr[1:0]!=0, withhold d_gnt, perform no access, and pulse d_misalign for one cycle (registered, next cycle); stall_mem SHALL stay 0 for that request.
REQ-020 SHALL drive stall_if = if_req & ~if_gnt & ~if_kill and stall_mem = d_req & ~d_gnt & aligned.
REQ-021 SHALL allow back-to-back grants every cycle; throughput 1 access/cycle, read latency 1.

Reset
REQ-022 SHALL, while init_n=0, asynchronously force tag=NONE, starve_cnt=0 and d_misalign=0, and hold all grants, valids and mem_cs at 0.
REQ-023 SHALL drop an in-flight response on reset assertion mid-access; no rvalid is produced after deassertion.
REQ-024 SHALL accept the first grant on the first rising edge after init_n rises.

Structure
REQ-025 SHALL place the tag state encoding (NONE=2'd0, IF_RD=2'd1, D_RD=2'd2) and the default STARVE_MAX in the shared processor package.
REQ-026 SHALL instantiate one sub-module, starve_counter (saturating counter with clear), with the grant/tag logic kept in mem_port_arbiter.

Verification
REQ-027 SHALL cover: if_req only, addr 0x00400020, mem_dout=0x8C020004 -> if_gnt same cycle, if_rvalid=1 and if_rdata=0x8C020004 next cycle.
REQ-028 SHALL cover: if_req and d_req (read 0x10010000) held together for 6 cycles -> d_gnt in cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6; stall_if=1 in cycles 1-4.
REQ-029 SHALL cover: d_req with d_we=1, addr 0x10010004, data 0xDEADBEEF -> mem_we=1, mem_din=0xDEADBEEF, no d_rvalid next cycle.
REQ-030 SHALL cover: fetch granted, if_kill=1 next cycle -> if_rvalid stays 0 and tag returns to NONE.
REQ-031 SHALL cover: d_addr=0x10010002 -> d_gnt=0, mem_cs=0, d_misalign=1 for exactly one cycle.
REQ-032 SHALL cover: init_n pulsed low during D_RD -> d_rvalid never asserts and all outputs are 0 until the next grant.
